// File: rtl/tetris_title_renderer_if.sv
// tetris_title_renderer_if: scan position, animation control, ROM and pixel signals of the title renderer
interface tetris_title_renderer_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic frame_tick;
  logic anim_en;
  logic [3:0] font_addr;
  logic [59:0] font_data;
  logic [2:0] color_addr;
  logic [11:0] color_data;
  logic title_on;
  logic [11:0] title_rgb;
  modport master (
    output DrawX, DrawY, frame_tick, anim_en, font_data, color_data,
    input font_addr, color_addr, title_on, title_rgb
  );
  modport slave (
    input DrawX, DrawY, frame_tick, anim_en, font_data, color_data,
    output font_addr, color_addr, title_on, title_rgb
  );
endinterface

// File: rtl/tetris_title_renderer.sv
// tetris_title_renderer: two-stage pipeline drawing the animated "TETRIS" banner from font/colour ROMs
module tetris_title_renderer #(
  parameter int TITLE_X0 = 400,
  parameter int TITLE_Y0 = 40,
  parameter int SCALE = 3,
  parameter int ANIM_FRAMES = 30
) (
  input logic Clk,
  input logic Reset,
  tetris_title_renderer_if.slave bus
);
  localparam logic [10:0] X0 = 11'(TITLE_X0);
  localparam logic [10:0] X1 = 11'(TITLE_X0 + 60 * SCALE);
  localparam logic [10:0] Y0 = 11'(TITLE_Y0);
  localparam logic [10:0] Y1 = 11'(TITLE_Y0 + 10 * SCALE);
  localparam logic [9:0] SC = 10'(SCALE);
  localparam logic [7:0] LAST = 8'(ANIM_FRAMES - 1);
  logic in_box_q, in_box_d;
  logic [3:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic [2:0] letter_q, letter_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] offset_q, offset_d;
  logic title_on_q, title_on_d;
  logic [11:0] title_rgb_q, title_rgb_d;
  logic [9:0] rel_x, rel_y;
  logic [3:0] sum;
  logic hit, adv;
  always_comb begin
    rel_x = bus.DrawX - X0[9:0];
    rel_y = bus.DrawY - Y0[9:0];
    in_box_d = {1'b0, bus.DrawX} >= X0 && {1'b0, bus.DrawX} < X1 &&
               {1'b0, bus.DrawY} >= Y0 && {1'b0, bus.DrawY} < Y1;
    // rel_x/rel_y wrap left of / above the banner, so in_box gates them
    col_d = in_box_d ? 6'(rel_x / SC) : 6'd0;
    row_d = in_box_d ? 4'(rel_y / SC) : 4'd0;
    letter_d = 3'(col_d / 6'd10);
    sum = {1'b0, letter_q} + {1'b0, offset_q};
    hit = in_box_q & bus.font_data[6'd59 - col_q];
    title_on_d = hit;
    title_rgb_d = hit ? bus.color_data : 12'h000;
    adv = bus.frame_tick & bus.anim_en;
    frame_cnt_d = !adv ? frame_cnt_q : (frame_cnt_q == LAST) ? 8'd0 : frame_cnt_q + 8'd1;
    offset_d = (adv && frame_cnt_q == LAST) ? ((offset_q == 3'd5) ? 3'd0 : offset_q + 3'd1) : offset_q;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_box_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      letter_q <= '0;
      frame_cnt_q <= '0;
      offset_q <= '0;
      title_on_q <= 1'b0;
      title_rgb_q <= '0;
    end else begin
      in_box_q <= in_box_d;
      row_q <= row_d;
      col_q <= col_d;
      letter_q <= letter_d;
      frame_cnt_q <= frame_cnt_d;
      offset_q <= offset_d;
      title_on_q <= title_on_d;
      title_rgb_q <= title_rgb_d;
    end
  end
  assign bus.font_addr = in_box_q ? row_q : 4'd0;
  assign bus.color_addr = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
  assign bus.title_on = title_on_q;
  assign bus.title_rgb = title_rgb_q;
endmodule
